// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand/opcode entry sequencer.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_NOT = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_RSV = 3'b110;
  localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// rising-edge pulse. The level only moves after DEBOUNCE_CYCLES consecutive
// synchronized samples that disagree with it.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized input disagrees with the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Synchronizer, debounced level and its one-cycle delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/alu_cmd_seq.sv
// Operand/opcode entry sequencer for the board ALU.
//
//   state  | meaning
//   S_A    | waiting for press to latch operand A from sw
//   S_B    | waiting for press to latch operand B from sw
//   S_OP   | waiting for press to latch opcode from sw[2:0]
//   S_EXEC | one cycle: ALU result has settled, capture it
//   S_SHOW | result displayed; press returns to S_A
//
// Codes 5..7 are never entered; if seen they fall back to S_A.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn,
  input  logic              clr,
  input  logic [DATA_W-1:0] res,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [2:0]        state
);

  logic press;
  logic btn_level;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn),
    .level_o(btn_level),
    .press_o(press)
  );

  // Next-state and register updates; clr overrides any press this cycle.
  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    valid_d  = valid_q;
    if (clr) begin
      state_d  = S_A;
      alu_a_d  = '0;
      alu_b_d  = '0;
      alu_op_d = '0;
      result_d = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (press) begin
            alu_a_d = sw;
            state_d = S_B;
          end
        end
        S_B: begin
          if (press) begin
            alu_b_d = sw;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (press) begin
            alu_op_d = sw[OP_W-1:0];
            state_d  = S_EXEC;
          end
        end
        S_EXEC: begin
          result_d = res;
          valid_d  = 1'b1;
          state_d  = S_SHOW;
        end
        S_SHOW: begin
          if (press) begin
            valid_d = 1'b0;
            state_d = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_A;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq with a reference ALU driving res.
module tb_alu_cmd_seq;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn;
  logic       clr;
  logic [3:0] res;
  logic [3:0] alu_a, alu_b, result;
  logic [2:0] alu_op, state;
  logic       result_valid;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Behavioural model of the entry sequence.
  int         m_phase;
  logic [3:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  logic       m_valid;

  alu_cmd_seq #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .btn         (btn),
    .clr         (clr),
    .res         (res),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .result      (result),
    .result_valid(result_valid),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return 4'd0;
      default: return (a == b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign res = alu_ref(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_a = 4'd0; m_b = 4'd0; m_op = 3'd0; m_res = 4'd0; m_valid = 1'b0;
  endtask

  task automatic model_press(input logic [3:0] s);
    case (m_phase)
      0: begin m_a = s; m_phase = 1; end
      1: begin m_b = s; m_phase = 2; end
      2: begin
        m_op    = s[2:0];
        m_res   = alu_ref(m_a, m_b, m_op);
        m_valid = 1'b1;
        m_phase = 4;
      end
      default: begin m_valid = 1'b0; m_phase = 0; end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, 32'(state), 32'(m_phase));
    check({tag, ".a"}, 32'(alu_a), 32'(m_a));
    check({tag, ".b"}, 32'(alu_b), 32'(m_b));
    check({tag, ".op"}, 32'(alu_op), 32'(m_op));
    check({tag, ".result"}, 32'(result), 32'(m_res));
    check({tag, ".valid"}, 32'(result_valid), 32'(m_valid));
  endtask

  // Hold btn for 'hold' synchronized samples, then release and let it settle.
  task automatic press(input int hold, input logic [3:0] s);
    sw  = s;
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    if (hold >= N) model_press(s);
  endtask

  task automatic to_phase0();
    for (int i = 0; i < 4 && m_phase != 0; i++) press(6, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    model_reset();
    sw = 4'd0; btn = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Add 3+5 with precise press-to-result timing on the opcode press.
    press(6, 4'd3);
    press(6, 4'd5);
    sw = 4'd0; btn = 1'b1;
    repeat (N) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    check("add.no_early_advance", 32'(state), 32'd2);
    @(negedge clk);
    check("add.exec_state", 32'(state), 32'd3);
    check("add.exec_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    check("add.show_state", 32'(state), 32'd4);
    check("add.show_valid", 32'(result_valid), 32'd1);
    check("add.result", 32'(result), 32'd8);
    model_press(4'd0);
    repeat (10) @(negedge clk);
    check_model("add");
    press(6, 4'd9);
    check_model("add.back");

    // Subtraction that wraps, then return to S_A keeping operand A.
    press(6, 4'd2);
    press(6, 4'd5);
    press(6, 4'd1);
    check("sub.result", 32'(result), 32'hD);
    check_model("sub");
    press(6, 4'd7);
    check_model("sub.back");

    // Short glitches are rejected; a long hold advances exactly once.
    for (int h = 1; h < N; h++) begin
      press(h, 4'($urandom_range(0, 15)));
      check_model("glitch");
    end
    press(100, 4'd6);
    check_model("hold100");
    to_phase0();

    // Randomized entry rounds with occasional glitches.
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 3) == 0) press($urandom_range(1, N - 1), 4'($urandom_range(0, 15)));
        press($urandom_range(N, 15), 4'($urandom_range(0, 15)));
        check_model("rand");
      end
    end

    // clr in the same cycle as the opcode press.
    to_phase0();
    press(6, 4'd4);
    press(6, 4'd6);
    sw = 4'd5; btn = 1'b1;
    repeat (N) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    check_model("clr");
    repeat (12) @(negedge clk);
    check_model("clr.settle");

    // Reset while in S_EXEC holding a stale nonzero result.
    press(6, 4'd7);
    press(6, 4'd1);
    press(6, 4'd0);
    press(6, 4'd0);
    press(6, 4'd3);
    press(6, 4'd3);
    sw = 4'd1; btn = 1'b1;
    repeat (N) @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    check("rstop.in_exec", 32'(state), 32'd3);
    check("rstop.stale_result", 32'(result), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rstop");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    press(6, 4'd9);
    check_model("rstop.first_press");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Operand/opcode entry sequencer that drives the 4-bit board ALU from the slide switches and one push button. It debounces the button, walks an entry state machine (A, B, op) and drives registered operands to the ALU. It captures the ALU's combinational result and holds it for the seven-segment path. It is the initiator/input side of the ALU, sitting between board I/O and the ALU/display logic.

## Interface
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required before the debounced button level changes; legal range ≥1.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- sw  in  4  slide-switch data; sampled only on an accepted press.
- btn  in  1  raw push button, active-high, asynchronous to clk.
- clr  in  1  synchronous abort, active-high, level.
- res  in  4  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_a  out  4  registered operand A.
- alu_b  out  4  registered operand B.
- alu_op  out  3  registered opcode.
- result  out  4  captured ALU result.
- result_valid  out  1  high while result is displayed.
- state  out  3  current FSM state, for status LEDs.

## Operation
- Reset (async, rst_n=0): alu_a=0, alu_b=0, alu_op=0, result=0, result_valid=0, state=S_A; sync flops, debounced level, counter and edge register all 0.
- btn path: 2-flop synchronizer, then debouncer. The counter resets to 0 whenever sync equals the debounced level. Otherwise it increments. When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
- press = debounced & ~debounced_q. This is a one-cycle pulse and fires once per debounced rising edge, however long the button is held. Release never produces a press.
- FSM, evaluated on each clk edge:
  - S_A(0): on press, alu_a<=sw, go to S_B.
  - S_B(1): on press, alu_b<=sw, go to S_OP.
  - S_OP(2): on press, alu_op<=sw[2:0], go to S_EXEC.
  - S_EXEC(3): unconditional, one cycle. result<=res, result_valid<=1, go to S_SHOW.
  - S_SHOW(4): on press, result_valid<=0, go to S_A. Operands keep their values.
  - Codes 5–7 are unreachable. If entered, go to S_A next edge.
- clr=1 has priority over press in every state: state<=S_A, alu_a/alu_b/alu_op/result<=0, result_valid<=0. The press in that cycle is discarded.
- Arithmetic: no arithmetic in this block. The captured result is 4 bits and wraps exactly as the ALU produces it. Opcodes 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 reserved (result 0), 111 eq (result 0 or 1).

## Timing
- Raw btn high, first sampled at edge 1: sync high after edge 2, debounced high after edge 2+DEBOUNCE_CYCLES, press high in the following cycle, FSM transition at edge 3+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles are fully rejected.
- S_OP press to result_valid=1: 2 edges. The op-latch edge is followed by the S_EXEC capture edge.
- res must settle within one cycle of the alu_* registers updating.
- rst_n assertion takes effect immediately, with no clock required. Deassertion is synchronized externally.

## Structure
- Package alu_pkg: state localparams S_A…S_SHOW (3-bit), opcode constants OP_ADD…OP_EQ (3-bit), data width constant 4.
- Sub-module btn_debounce (synchronizer, counter, edge pulse) with parameter DEBOUNCE_CYCLES, outputs level and press. Counter width is $clog2(DEBOUNCE_CYCLES+1).

## Test plan
Bench uses DEBOUNCE_CYCLES=4, with res driven by a reference ALU model.
- Reset: hold rst_n=0 mid-stream → all outputs 0, state=0, with no clock edge needed.
- Add: presses with sw=3, 5, 0 → alu_a=3, alu_b=5, alu_op=000; result=8 and result_valid=1 exactly 2 edges after the third press pulse; state=4.
- Sub wrap: A=2, B=5, op=001 → result=4'hD. A further press clears result_valid, state=0, alu_a stays 2.
- Debounce: btn high 3 synchronized cycles → no transition. Btn high 4 cycles → exactly one advance, at edge 7 after first sample. Btn held 100 cycles → still one advance.
- clr priority: in S_OP, assert clr in the same cycle as press → state=S_A, operands 0, alu_op unchanged from 0.
- Reset mid-op: drop rst_n in S_EXEC → result_valid=0 and result=0 immediately. After release, the first press loads alu_a.
